// File: rtl/data_deshuffler.sv
// Tile-to-beat serializer: accepts SpatPar x SpatPar element tiles, optionally transposes, streams SpatPar beats.
// Optional saturating tile counter output enabled by defining DATA_DESHUFFLER_TILE_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a tile; CSR writes accepted here only
// DRAIN | emitting buffer[beat_cnt]; last beat may chain straight into the next tile
module data_deshuffler #(
   parameter int SpatPar   = 8,
   parameter int DataWidth = 64,
   parameter int Elems     = DataWidth / SpatPar
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [SpatPar*DataWidth-1:0] a_i,
   input  logic                         a_valid_i,
   output logic                         a_ready_o,
   output logic [DataWidth-1:0]         z_o,
   output logic                         z_valid_o,
   input  logic                         z_ready_i,
   input  logic [31:0]                  csr_en_transpose_i,
   input  logic                         csr_valid_i,
   output logic                         csr_ready_o
`ifdef DATA_DESHUFFLER_TILE_CNT_EN
   ,
   output logic [31:0]                  tile_cnt_o
`endif
);

   localparam int CntW = $clog2(SpatPar);
   localparam logic [CntW-1:0] LastBeat = CntW'(SpatPar - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t               state;
   logic [CntW-1:0]      beat_cnt;
   logic [31:0]          transpose;
   logic [DataWidth-1:0] buffer [SpatPar];
   logic [DataWidth-1:0] tile   [SpatPar];
   logic                 z_fire;
   logic                 last_beat;
   logic                 load;

   // Beat k is row k, or column k when transposing (element (j,k) in slot j).
   always_comb begin
      for (int k = 0; k < SpatPar; k++) begin
         tile[k] = '0;
         for (int j = 0; j < SpatPar; j++) begin
            if (|transpose)
               tile[k][j*Elems +: Elems] = a_i[(j*SpatPar+k)*Elems +: Elems];
            else
               tile[k][j*Elems +: Elems] = a_i[(k*SpatPar+j)*Elems +: Elems];
         end
      end
   end

   assign z_valid_o   = (state == DRAIN);
   assign z_o         = z_valid_o ? buffer[beat_cnt] : '0;
   assign z_fire      = z_valid_o && z_ready_i;
   assign last_beat   = (beat_cnt == LastBeat);
   assign a_ready_o   = (state == IDLE) || (z_fire && last_beat);
   assign csr_ready_o = (state == IDLE);
   assign load        = a_valid_i && a_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         transpose <= '0;
         for (int k = 0; k < SpatPar; k++)
            buffer[k] <= '0;
      end else begin
         // A tile accepted together with a CSR write still uses the old mode.
         if (csr_valid_i && csr_ready_o)
            transpose <= csr_en_transpose_i;
         if (load) begin
            buffer   <= tile;
            beat_cnt <= '0;
            state    <= DRAIN;
         end else if (z_fire) begin
            if (last_beat) begin
               beat_cnt <= '0;
               state    <= IDLE;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

`ifdef DATA_DESHUFFLER_TILE_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         tile_cnt_o <= '0;
      else if (z_fire && last_beat && tile_cnt_o != 32'hFFFF_FFFF)
         tile_cnt_o <= tile_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_data_deshuffler.sv
// Directed bench for data_deshuffler: table of hand-computed beats plus multi-cycle corner sequences.
// Counter checks are compiled in when DATA_DESHUFFLER_TILE_CNT_EN is defined.
module tb_data_deshuffler;
   localparam int SP = 8;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [SP*DW-1:0] a;
   logic            a_valid;
   logic            a_ready;
   logic [DW-1:0]   z;
   logic            z_valid;
   logic            z_ready;
   logic [31:0]     csr_en;
   logic            csr_valid;
   logic            csr_ready;
`ifdef DATA_DESHUFFLER_TILE_CNT_EN
   logic [31:0]     tile_cnt;
`endif

   data_deshuffler #(.SpatPar(SP), .DataWidth(DW)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .a_i                (a),
      .a_valid_i          (a_valid),
      .a_ready_o          (a_ready),
      .z_o                (z),
      .z_valid_o          (z_valid),
      .z_ready_i          (z_ready),
      .csr_en_transpose_i (csr_en),
      .csr_valid_i        (csr_valid),
      .csr_ready_o        (csr_ready)
`ifdef DATA_DESHUFFLER_TILE_CNT_EN
      ,
      .tile_cnt_o         (tile_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] got [SP];

   typedef struct {
      logic [7:0]  seed;
      logic        tr;
      int          k;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Element (i,j) = 8'h{i,j} + seed; seeds chosen so no byte overflows.
   function automatic logic [SP*DW-1:0] make_tile(input logic [7:0] seed);
      logic [SP*DW-1:0] t;
      t = '0;
      for (int i = 0; i < SP; i++)
         for (int j = 0; j < SP; j++)
            t[(i*SP+j)*8 +: 8] = 8'(i*16 + j) + seed;
      return t;
   endfunction

   function automatic logic [63:0] exp_beat(input logic [7:0] seed, input logic tr, input int k);
      logic [63:0] b;
      b = '0;
      for (int j = 0; j < SP; j++)
         b[j*8 +: 8] = (tr ? 8'(j*16 + k) : 8'(k*16 + j)) + seed;
      return b;
   endfunction

   task automatic write_csr(input logic [31:0] v);
      @(negedge clk);
      csr_en    = v;
      csr_valid = 1'b1;
      #1 chk("csr_ready_idle", csr_ready, 1);
      @(negedge clk);
      csr_valid = 1'b0;
   endtask

   // Returns at the negedge where the first beat should be valid.
   task automatic send_one(input logic [SP*DW-1:0] t);
      @(negedge clk);
      a       = t;
      a_valid = 1'b1;
      #1 chk("a_ready_idle", a_ready, 1);
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   task automatic collect(input int first);
      for (int k = first; k < SP; k++) begin
         #1 chk("beat_valid", z_valid, 1);
         got[k] = z;
         @(negedge clk);
      end
      #1 chk("valid_fall", z_valid, 0);
   endtask

   initial begin
      logic pat [4];
      int   idx, cyc, beats, sent;
      logic stalled, hs;
      logic [DW-1:0] held;
      logic [7:0] seeds [3];

      vecs[0] = '{8'h00, 1'b0, 3, 64'h3736353433323130};
      vecs[1] = '{8'h00, 1'b0, 0, 64'h0706050403020100};
      vecs[2] = '{8'h00, 1'b0, 7, 64'h7776757473727170};
      vecs[3] = '{8'h00, 1'b1, 3, 64'h7363534333231303};
      vecs[4] = '{8'h00, 1'b1, 0, 64'h7060504030201000};
      vecs[5] = '{8'h00, 1'b1, 7, 64'h7767574737271707};
      vecs[6] = '{8'h88, 1'b0, 2, 64'hAFAEADACABAAA9A8};
      vecs[7] = '{8'h88, 1'b1, 5, 64'hFDEDDDCDBDAD9D8D};
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      seeds[0] = 8'h00; seeds[1] = 8'h08; seeds[2] = 8'h80;

      rst = 1'b1; a = '0; a_valid = 1'b0; z_ready = 1'b1; csr_en = '0; csr_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_z_valid", z_valid, 0);
      chk("rst_z", z, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_csr_ready", csr_ready, 1);
      rst = 1'b0;

      // Table: one tile per record in the given mode, checking the listed beat and all beats.
      for (int v = 0; v < 8; v++) begin
         write_csr({31'b0, vecs[v].tr});
         send_one(make_tile(vecs[v].seed));
         collect(0);
         chk("tbl_beat", got[vecs[v].k], vecs[v].exp);
         for (int k = 0; k < SP; k++)
            chk("tbl_model", got[k], exp_beat(vecs[v].seed, vecs[v].tr, k));
      end

      // Back-to-back tiles, row mode.
      write_csr(32'd0);
      @(negedge clk);
      a = make_tile(seeds[0]); a_valid = 1'b1; z_ready = 1'b1;
      sent = 0; beats = 0; cyc = 0;
      while (beats < 24 && cyc < 60) begin
         #1;
         if (beats > 0) chk("b2b_nobubble", z_valid, 1);
         if (z_valid) begin
            chk("b2b_beat", z, exp_beat(seeds[beats/8], 1'b0, beats % 8));
            chk("b2b_aready", a_ready, (beats % 8 == 7));
            beats++;
         end
         hs = a_valid && a_ready;
         @(negedge clk);
         cyc++;
         if (hs) begin
            sent++;
            if (sent < 3) a = make_tile(seeds[sent]);
            else a_valid = 1'b0;
         end
      end
      chk("b2b_count", beats, 24);
      #1 chk("b2b_fall", z_valid, 0);

      // Backpressure with z_ready pattern 1,0,0,1.
      send_one(make_tile(8'h08));
      idx = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (idx < 8 && cyc < 64) begin
         z_ready = pat[cyc % 4];
         #1;
         chk("bp_valid", z_valid, 1);
         if (stalled) chk("bp_hold", z, held);
         chk("bp_beat", z, exp_beat(8'h08, 1'b0, idx));
         if (z_ready) begin
            idx++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = z;
         end
         @(negedge clk);
         cyc++;
      end
      z_ready = 1'b1;
      chk("bp_done", idx, 8);
      #1 chk("bp_fall", z_valid, 0);

      // CSR write attempted during DRAIN is refused.
      send_one(make_tile(8'h00));
      csr_en = 32'd1; csr_valid = 1'b1;
      #1 chk("csr_ready_drain", csr_ready, 0);
      got[0] = z;
      @(negedge clk);
      csr_valid = 1'b0;
      collect(1);
      chk("drain_csr_beat3", got[3], 64'h3736353433323130);
      send_one(make_tile(8'h00));
      collect(0);
      chk("drain_csr_after", got[3], 64'h3736353433323130);

      // CSR write and tile accept in the same IDLE cycle: tile uses the old mode.
      @(negedge clk);
      csr_en = 32'h0000_0100; csr_valid = 1'b1;
      a = make_tile(8'h00); a_valid = 1'b1;
      #1 chk("same_cyc_aready", a_ready, 1);
      @(negedge clk);
      csr_valid = 1'b0; a_valid = 1'b0;
      collect(0);
      chk("same_cyc_old_mode", got[3], 64'h3736353433323130);
      send_one(make_tile(8'h00));
      collect(0);
      chk("same_cyc_new_mode", got[3], 64'h7363534333231303);

      // Reset at beat 4.
      send_one(make_tile(8'h00));
      repeat (4) @(negedge clk);
      #1 chk("pre_rst_valid", z_valid, 1);
      chk("pre_rst_beat4", z, 64'h7464544434241404);
      rst = 1'b1;
      #1 chk("rst_async_valid", z_valid, 0);
      chk("rst_async_z", z, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_aready", a_ready, 1);
      chk("post_rst_csr_ready", csr_ready, 1);
      send_one(make_tile(8'h00));
      collect(0);
      chk("post_rst_mode", got[3], 64'h3736353433323130);

`ifdef DATA_DESHUFFLER_TILE_CNT_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("cnt_reset", tile_cnt, 0);
      for (int t = 0; t < 5; t++) begin
         send_one(make_tile(8'h00));
         collect(0);
      end
      chk("cnt_five", tile_cnt, 5);
      rst = 1'b1;
      #1 chk("cnt_cleared", tile_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
